multi_digit_adder_display: RTL

//  Parametrised N-digit hex add/subtract unit with a time-multiplexed seven-segment driver.

---
 rtl/multi_digit_adder_display_if.sv | 16 +
 rtl/multi_digit_adder_display.sv | 90 +++++++++
 2 files changed

// File: rtl/multi_digit_adder_display_if.sv
// Operand/strobe inputs and display outputs of the hex add/subtract display block.
// The master drives operands and the load strobe; the slave (the display block) drives the display.
interface multi_digit_adder_display_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic                  sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic [6:0]            d;
  logic                  Overflow;
  logic [DIGITS-1:0]     AN;

  modport master (output load, sub, a, b, input d, Overflow, AN);
  modport slave  (input load, sub, a, b, output d, Overflow, AN);
endinterface

// File: rtl/multi_digit_adder_display.sv
// N-digit hex add/subtract unit with a registered result, scanned one digit at a time
// onto common-anode seven-segment displays (anodes and segments active-low).
module multi_digit_adder_display #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  multi_digit_adder_display_if.slave    bus
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [W-1:0]  result;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [W:0]    operand_b;
  logic [W:0]    sum;
  logic          overflow_next;
  logic [3:0]    nibble;
  logic [6:0]    seg;
  logic          presc_wrap;
  logic          last_digit;

  // Subtraction is a + ~b + 1; the extra top bit is carry for add and not-borrow for sub.
  always_comb begin
    operand_b     = bus.sub ? {1'b0, ~bus.b} : {1'b0, bus.b};
    sum           = {1'b0, bus.a} + operand_b + {{W{1'b0}}, bus.sub};
    overflow_next = bus.sub ? sum[W] : ~sum[W];
  end

  always_comb begin
    presc_wrap = (presc == PW'(REFRESH_DIV - 1));
    last_digit = (idx == IW'(DIGITS - 1));
    nibble     = 4'(result >> {idx, 2'b00});
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    seg = 7'h7F;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      result       <= '0;
      bus.Overflow <= 1'b1;
      presc        <= '0;
      idx          <= '0;
      bus.AN       <= '1;
      bus.d        <= 7'h7F;
    end else begin
      if (bus.load) begin
        result       <= sum[W-1:0];
        bus.Overflow <= overflow_next;
      end

      if (presc_wrap) begin
        presc <= '0;
        idx   <= last_digit ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      // Display is registered from the current digit, so it trails idx/result by one cycle.
      bus.AN <= ~(DIGITS'(1) << idx);
      bus.d  <= seg;
    end
  end
endmodule
